// File: rtl/pwm_pkg.sv
// pwm_pkg: default PWM geometry, counter width helper and duty clamp shared by pwm_gen and pwm_prescaler
package pwm_pkg;
  localparam int unsigned PRESCALE_DEF = 10;
  localparam int unsigned STEPS_DEF = 100;
  localparam int unsigned PAR_W_DEF = 32;
  function automatic int unsigned cnt_w(input int unsigned n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] duty_clamp(input logic [63:0] par, input int unsigned steps);
    return par >= 64'(steps) ? steps : par[31:0];
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: free-running 0..PRESCALE-1 counter (sclk, rst in; pre_cnt, tick out) with tick on the last count
module pwm_prescaler import pwm_pkg::*; #(
  parameter int unsigned PRESCALE = PRESCALE_DEF,
  localparam int unsigned PRE_W = cnt_w(PRESCALE)
) (
  input  logic             sclk,
  input  logic             rst,
  output logic [PRE_W-1:0] pre_cnt,
  output logic             tick
);
  assign tick = pre_cnt == PRE_W'(PRESCALE - 1);
  always_ff @(posedge sclk)
    pre_cnt <= rst || tick ? '0 : pre_cnt + 1'b1;
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: percent-duty PWM (sclk, rst, pwm_par in; pwm_out out); define PWM_SHADOW_EN to apply duty changes only at period start
module pwm_gen import pwm_pkg::*; #(
  parameter int unsigned PRESCALE = PRESCALE_DEF,
  parameter int unsigned STEPS = STEPS_DEF,
  parameter int unsigned PAR_W = PAR_W_DEF,
  localparam int unsigned PRE_W = cnt_w(PRESCALE),
  localparam int unsigned STEP_W = cnt_w(STEPS),
  localparam int unsigned DUTY_W = $clog2(STEPS + 1)
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [PAR_W-1:0] pwm_par,
  output logic             pwm_out
);
  logic [PRE_W-1:0] pre_cnt;
  logic tick, period_start;
  logic [STEP_W-1:0] step_cnt;
  logic [DUTY_W-1:0] duty_eff, duty_q, duty_cmp, duty_d;
  pwm_prescaler #(.PRESCALE(PRESCALE)) u_pre (.sclk(sclk), .rst(rst), .pre_cnt(pre_cnt), .tick(tick));
  assign period_start = pre_cnt == '0 && step_cnt == '0;
  assign duty_eff = DUTY_W'(duty_clamp(64'(pwm_par), STEPS));
`ifdef PWM_SHADOW_EN
  assign duty_cmp = period_start ? duty_eff : duty_q;
  assign duty_d = duty_cmp;
`else
  assign duty_cmp = duty_q;
  assign duty_d = duty_eff;
`endif
  always_ff @(posedge sclk) begin
    step_cnt <= rst ? '0 : !tick ? step_cnt : step_cnt == STEP_W'(STEPS - 1) ? '0 : step_cnt + 1'b1;
    duty_q <= rst ? '0 : duty_d;
    pwm_out <= !rst && DUTY_W'(step_cnt) < duty_cmp;
  end
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: pulse-run scoreboard bench for pwm_gen, expectations for both PWM_SHADOW_EN settings
module tb_pwm_gen;
  typedef struct {logic lvl; int len;} run_t;
`ifdef PWM_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif
  logic sclk = 1'b0, rst = 1'b1, pwm_out;
  logic [31:0] pwm_par = 32'd10;
  int tests = 0, fails = 0, edge_k = 0, run_len = 0, bad = 0;
  logic cur = 1'b0;
  run_t q[$];
  run_t e;
  pwm_gen dut (.sclk(sclk), .rst(rst), .pwm_par(pwm_par), .pwm_out(pwm_out));
  always #5 sclk = ~sclk;
  always @(posedge sclk) edge_k <= rst ? 0 : edge_k + 1;
  task automatic exp_run(input logic l, input int n);
    q.push_back('{l, n});
  endtask
  task automatic wait_k(input int m);
    while (edge_k < m) @(negedge sclk);
  endtask
  always @(negedge sclk) begin
    if (pwm_out === cur) run_len++;
    else begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL extra_run: got level %b len %0d, expected no further edge", cur, run_len);
      end else begin
        e = q.pop_front();
        if (e.lvl !== cur || (e.len != 0 && e.len != run_len)) begin
          fails++;
          $display("FAIL run_%0d: got level %b len %0d, expected level %b len %0d", tests, cur, run_len, e.lvl, e.len);
        end
      end
      cur = pwm_out;
      run_len = 1;
    end
  end
  initial begin
    exp_run(1'b0, 0);
    exp_run(1'b1, SH ? 100 : 99);
    exp_run(1'b0, 900);
    for (int p = 1; p < 5; p++) begin
      exp_run(1'b1, 100);
      exp_run(1'b0, 900);
    end
    exp_run(1'b1, 100);
    repeat (20) begin
      @(negedge sclk);
      if (pwm_out !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_low: got %0d high cycles in reset, expected 0", bad);
    end
    rst = 1'b0;
    wait_k(5200);
    pwm_par = 32'd50;
    if (SH) begin
      exp_run(1'b0, 900); exp_run(1'b1, 500); exp_run(1'b0, 500); exp_run(1'b1, 500);
    end else begin
      exp_run(1'b0, 101); exp_run(1'b1, 299); exp_run(1'b0, 500);
      exp_run(1'b1, 500); exp_run(1'b0, 500); exp_run(1'b1, 500);
    end
    wait_k(7600);
    pwm_par = 32'd0;
    wait_k(10500);
    pwm_par = 32'd100;
    exp_run(1'b0, SH ? 3500 : 3001);
    wait_k(12500);
    pwm_par = 32'hFFFF_FFFF;
    wait_k(14200);
    pwm_par = 32'd1;
    if (SH) begin
      exp_run(1'b1, 4010); exp_run(1'b0, 990); exp_run(1'b1, 5);
    end else begin
      exp_run(1'b1, 3700); exp_run(1'b0, 799); exp_run(1'b1, 10); exp_run(1'b0, 990); exp_run(1'b1, 5);
    end
    wait_k(16005);
    rst = 1'b1;
    exp_run(1'b0, 0);
    exp_run(1'b1, SH ? 10 : 9);
    exp_run(1'b0, 990);
    exp_run(1'b1, 10);
    repeat (10) @(negedge sclk);
    rst = 1'b0;
    wait_k(1500);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_runs: got %0d runs still pending, expected 0", q.size());
    end
    tests++;
    if (pwm_out !== 1'b0) begin
      fails++;
      $display("FAIL final_low: got %b, expected 0", pwm_out);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
